// File: rtl/piece_action_arbiter_if.sv
// Action handshake between the arbiter (master) and the game logic (slave).
// A transfer happens on any clock edge where action_valid && action_ready.
interface piece_action_arbiter_if;
  logic       action_valid;
  logic [2:0] action;
  logic       action_ready;

  modport master (
    output action_valid,
    output action,
    input  action_ready
  );

  modport slave (
    input  action_valid,
    input  action,
    output action_ready
  );
endinterface

// File: rtl/piece_action_arbiter.sv
// Buffers keyboard motions in a FIFO, generates periodic gravity drops and
// round-robin arbitrates both onto one action port. Optional: GRAVITY_LEVEL_EN.
module piece_action_arbiter #(
  parameter int FIFO_DEPTH    = 4,
  parameter int GRAVITY_TICKS = 25000000,
  parameter int CNT_W         = 25
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [1:0]                  motion_i,
  input  logic                        motion_enable_i,
  input  logic                        pause_i,
`ifdef GRAVITY_LEVEL_EN
  input  logic [3:0]                  level_i,
`endif
  piece_action_arbiter_if.master      act_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_o,
  output logic                        overflow_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(FIFO_DEPTH);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] OFFER_KEY  = 2'd1;
  localparam logic [1:0] OFFER_GRAV = 2'd2;

  localparam logic GRANT_KEY  = 1'b0;
  localparam logic GRANT_GRAV = 1'b1;

  localparam logic [2:0] ACTION_DROP = 3'b100;

  logic [1:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             overflow_q, overflow_d;

  logic [CNT_W-1:0] grav_cnt_q, grav_cnt_d;
  logic             grav_pending_q, grav_pending_d;
  logic [CNT_W-1:0] period_m1;
  logic             grav_tick;

  logic [1:0]       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             action_valid_q, action_valid_d;
  logic [2:0]       action_q, action_d;

  logic             fifo_full;
  logic             key_pending;
  logic             transfer;
  logic             key_pop;
  logic             grav_pop;
  logic             push_ok;

  assign fifo_full   = (count_q == FULL_COUNT);
  assign key_pending = (count_q != '0);
  assign transfer    = action_valid_q && act_o.action_ready;
  assign key_pop     = transfer && (state_q == OFFER_KEY);
  assign grav_pop    = transfer && (state_q == OFFER_GRAV);
  // A full FIFO still accepts a command when the head leaves in the same cycle.
  assign push_ok     = motion_enable_i && (!fifo_full || key_pop);

  // ---------------------------------------------------------------- FIFO
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= motion_i;
    end
  end

  always_comb begin
    wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = key_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    overflow_d = overflow_q | (motion_enable_i & ~push_ok);
    count_d    = count_q;
    if (push_ok && !key_pop) begin
      count_d = count_q + 1'b1;
    end else if (!push_ok && key_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // ------------------------------------------------------- gravity timer
`ifdef GRAVITY_LEVEL_EN
  logic [31:0] period_sh;
  assign period_sh = 32'(GRAVITY_TICKS) >> level_i;
  assign period_m1 = (period_sh < 32'd2) ? CNT_W'(1) : CNT_W'(period_sh - 32'd1);
`else
  assign period_m1 = CNT_W'(GRAVITY_TICKS - 1);
`endif

  // >= rather than == so a shortened period reloads at once if already passed.
  assign grav_tick = !pause_i && (grav_cnt_q >= period_m1);

  always_comb begin
    grav_cnt_d = grav_cnt_q;
    if (!pause_i) begin
      grav_cnt_d = grav_tick ? '0 : grav_cnt_q + 1'b1;
    end
    // An offered drop that is accepted is consumed even while paused.
    grav_pending_d = grav_tick | (grav_pending_q & ~grav_pop);
  end

  // ----------------------------------------------------------- arbiter FSM
  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    action_valid_d = action_valid_q;
    action_d       = action_q;
    case (state_q)
      IDLE: begin
        if (key_pending && (!grav_pending_q || last_grant_q == GRANT_GRAV)) begin
          state_d        = OFFER_KEY;
          action_valid_d = 1'b1;
          action_d       = {1'b0, mem_q[rd_ptr_q]};
        end else if (grav_pending_q) begin
          state_d        = OFFER_GRAV;
          action_valid_d = 1'b1;
          action_d       = ACTION_DROP;
        end
      end
      OFFER_KEY: begin
        if (act_o.action_ready) begin
          state_d        = IDLE;
          action_valid_d = 1'b0;
          last_grant_d   = GRANT_KEY;
        end
      end
      OFFER_GRAV: begin
        if (act_o.action_ready) begin
          state_d        = IDLE;
          action_valid_d = 1'b0;
          last_grant_d   = GRANT_GRAV;
        end
      end
      default: begin
        state_d        = IDLE;
        action_valid_d = 1'b0;
      end
    endcase
  end

  // ------------------------------------------------------------ registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      overflow_q     <= 1'b0;
      grav_cnt_q     <= '0;
      grav_pending_q <= 1'b0;
      state_q        <= IDLE;
      last_grant_q   <= GRANT_GRAV;
      action_valid_q <= 1'b0;
      action_q       <= '0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      overflow_q     <= overflow_d;
      grav_cnt_q     <= grav_cnt_d;
      grav_pending_q <= grav_pending_d;
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      action_valid_q <= action_valid_d;
      action_q       <= action_d;
    end
  end

  assign act_o.action_valid = action_valid_q;
  assign act_o.action       = action_q;
  assign fifo_count_o       = count_q;
  assign overflow_o         = overflow_q;

endmodule

// File: tb/tb_piece_action_arbiter.sv
// Directed bench for piece_action_arbiter (FIFO_DEPTH=4, GRAVITY_TICKS=8) with
// an expected-action scoreboard checked by a transfer monitor.
module tb_piece_action_arbiter;

  logic       clk;
  logic       rst_n;
  logic [1:0] motion;
  logic       motion_enable;
  logic       pause;
  logic [2:0] fifo_count;
  logic       overflow;
`ifdef GRAVITY_LEVEL_EN
  logic [3:0] level;
`endif

  piece_action_arbiter_if act_if ();

  piece_action_arbiter #(
    .FIFO_DEPTH    (4),
    .GRAVITY_TICKS (8),
    .CNT_W         (4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .motion_i        (motion),
    .motion_enable_i (motion_enable),
    .pause_i         (pause),
`ifdef GRAVITY_LEVEL_EN
    .level_i         (level),
`endif
    .act_o           (act_if),
    .fifo_count_o    (fifo_count),
    .overflow_o      (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [2:0] exp_q[$];

  bit grav_mode    = 1'b0;
  int drops        = 0;
  int last_drop    = -1;
  int keys_between = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Transfer monitor: samples mid low-phase, after the stimulus has settled.
  always @(negedge clk) begin
    #2;
    if (rst_n && act_if.action_valid && act_if.action_ready) begin
      $display("xfer cyc=%0d action=%b fifo_count=%0d", cyc, act_if.action, fifo_count);
      if (grav_mode) begin
        if (act_if.action == 3'b100) begin
          drops++;
          if (last_drop >= 0) begin
            chk("drop_period", 32'(cyc - last_drop), 32'd8);
            chk("keys_between_drops", 32'(keys_between), 32'd3);
          end
          last_drop    = cyc;
          keys_between = 0;
        end else begin
          keys_between++;
          chk("grav_mode_key", 32'(act_if.action), 32'b000);
        end
      end else begin
        chk("sb_not_empty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          logic [2:0] e;
          e = exp_q.pop_front();
          chk("sb_action", 32'(act_if.action), 32'(e));
        end
      end
    end
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic drive_key(input logic [1:0] m, input bit expect_out);
    motion        = m;
    motion_enable = 1'b1;
    if (expect_out) exp_q.push_back({1'b0, m});
  endtask

  initial begin
    logic [1:0] burst[5];
    bit any_valid;
    bit seen;

    rst_n               = 1'b0;
    motion              = 2'b00;
    motion_enable       = 1'b0;
    pause               = 1'b1;
    act_if.action_ready = 1'b1;
`ifdef GRAVITY_LEVEL_EN
    level = 4'd0;
`endif

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(act_if.action_valid), 32'd0);
    chk("rst_action", 32'(act_if.action), 32'd0);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single key, latency two cycles, one-cycle valid
    drive_key(2'b01, 1'b1);
    @(negedge clk);
    motion_enable = 1'b0;
    chk("single_count_n1", 32'(fifo_count), 32'd1);
    chk("single_valid_n1", 32'(act_if.action_valid), 32'd0);
    @(negedge clk);
    chk("single_valid_n2", 32'(act_if.action_valid), 32'd1);
    chk("single_action_n2", 32'(act_if.action), 32'b001);
    @(negedge clk);
    chk("single_valid_n3", 32'(act_if.action_valid), 32'd0);
    chk("single_count_n3", 32'(fifo_count), 32'd0);

    // Backpressure and ordering
    act_if.action_ready = 1'b0;
    drive_key(2'b00, 1'b1);
    @(negedge clk);
    drive_key(2'b10, 1'b1);
    @(negedge clk);
    drive_key(2'b11, 1'b1);
    @(negedge clk);
    motion_enable = 1'b0;
    chk("bp_count", 32'(fifo_count), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_valid", 32'(act_if.action_valid), 32'd1);
      chk("bp_hold_action", 32'(act_if.action), 32'b000);
      @(negedge clk);
    end
    act_if.action_ready = 1'b1;
    repeat (8) @(negedge clk);
    chk("bp_drained_count", 32'(fifo_count), 32'd0);
    chk("bp_sb_empty", 32'(exp_q.size()), 32'd0);

    // Overflow: five commands into a four-entry FIFO
    act_if.action_ready = 1'b0;
    burst[0] = 2'b01; burst[1] = 2'b10; burst[2] = 2'b11; burst[3] = 2'b00; burst[4] = 2'b01;
    for (int i = 0; i < 5; i++) begin
      drive_key(burst[i], i < 4);
      @(negedge clk);
    end
    motion_enable = 1'b0;
    chk("ovf_count", 32'(fifo_count), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    act_if.action_ready = 1'b1;
    repeat (12) @(negedge clk);
    chk("ovf_drained_count", 32'(fifo_count), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    chk("ovf_sb_empty", 32'(exp_q.size()), 32'd0);

    // Gravity with a permanently busy keyboard: round-robin every 8 cycles
    grav_mode = 1'b1;
    pause     = 1'b0;
    drive_key(2'b00, 1'b0);
    repeat (60) @(negedge clk);
    chk("grav_drop_count_min", 32'(drops >= 5), 32'd1);

    // Async reset in the middle of a stalled offer
    act_if.action_ready = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_rst_valid", 32'(act_if.action_valid), 32'd1);
    chk("pre_rst_count", 32'(fifo_count), 32'd4);
    chk("pre_rst_overflow", 32'(overflow), 32'd1);
    motion_enable = 1'b0;
    pause         = 1'b1;
    grav_mode     = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(act_if.action_valid), 32'd0);
    chk("arst_count", 32'(fifo_count), 32'd0);
    chk("arst_overflow", 32'(overflow), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n               = 1'b1;
    act_if.action_ready = 1'b1;
    any_valid = 1'b0;
    repeat (10) begin
      @(negedge clk);
      any_valid |= act_if.action_valid;
    end
    chk("post_rst_quiet", 32'(any_valid), 32'd0);

    // Pause at counter=5 for 20 cycles, then resume
    pause = 1'b0;
    repeat (5) @(negedge clk);
    pause     = 1'b1;
    any_valid = 1'b0;
    repeat (20) begin
      @(negedge clk);
      any_valid |= act_if.action_valid;
    end
    chk("pause_no_drop", 32'(any_valid), 32'd0);
    pause = 1'b0;
    exp_q.push_back(3'b100);
    @(negedge clk);
    chk("resume_valid_1", 32'(act_if.action_valid), 32'd0);
    @(negedge clk);
    chk("resume_valid_2", 32'(act_if.action_valid), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 3 && !seen; i++) begin
      @(negedge clk);
      if (act_if.action_valid) begin
        seen = 1'b1;
        chk("resume_drop_action", 32'(act_if.action), 32'b100);
      end
    end
    chk("resume_drop_seen", 32'(seen), 32'd1);
    pause = 1'b1;
    repeat (4) @(negedge clk);
    chk("final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
